tea_output_collector: RTL and testbench

Downstream stage of the parallel TEA decryptor scheduler. It samples the 64-bit plaintext stream the scheduler produces once per enabled clock cycle and drops the warm-up (garbage) blocks that follow reset. Valid blocks are buffered in a small FIFO and delivered as two 32-bit words per block over a valid/ready handshake, toward the bus/UART-side consumer.

---
 rtl/tea_output_collector.sv | 118 +++++++++++
 tb/tb_tea_output_collector.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tea_output_collector.sv
// rtl/tea_output_collector.sv - drops TEA scheduler warm-up blocks, buffers plaintext, serializes to 32-bit words
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   ena        scheduler enable; one block sampled per enabled cycle
//   inBlock64  scheduler plaintext block
//   flush      synchronous clear of buffered data and overflow flag
//   out_ready  consumer accepts outWord32
//   out_valid  outWord32 holds a valid word
//   outWord32  high half of head block first, then low half
//   out_last   outWord32 is the low half of the block
//   warm       warm-up finished, sampled blocks are stored
//   level      blocks held, including the one being serialized
//   overflow   sticky: a post-warm-up block was dropped on a full FIFO
module tea_output_collector #(
    parameter int WARMUP = 32,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic [63:0]                inBlock64,
    input  logic                       flush,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [31:0]                outWord32,
    output logic                       out_last,
    output logic                       warm,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    logic [CW-1:0] warm_cnt;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          word_lo;
    logic [63:0]   mem [DEPTH];

    logic full;
    logic handshake;
    logic pop;
    logic push_req;
    logic push;

    assign warm      = (warm_cnt == CW'(WARMUP));
    assign full      = (level == (AW + 1)'(DEPTH));
    assign out_valid = (level != '0);
    assign handshake = out_valid & out_ready;
    // A block leaves the FIFO only when its low half is accepted.
    assign pop       = handshake & word_lo;
    assign push_req  = ena & warm & ~flush;
    // Popping on the same edge frees a slot, so a full FIFO can still take the block.
    assign push      = push_req & (~full | pop);

    always_comb begin
        outWord32 = 32'h0;
        out_last  = 1'b0;
        if (out_valid) begin
            outWord32 = word_lo ? mem[head][31:0] : mem[head][63:32];
            out_last  = word_lo;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            warm_cnt <= '0;
            head     <= '0;
            tail     <= '0;
            level    <= '0;
            word_lo  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            // Warm-up progress is independent of flush.
            if (ena && !warm) begin
                warm_cnt <= warm_cnt + CW'(1);
            end
            if (flush) begin
                head     <= '0;
                tail     <= '0;
                level    <= '0;
                word_lo  <= 1'b0;
                overflow <= 1'b0;
            end else begin
                if (push) begin
                    tail <= tail + AW'(1);
                end
                if (handshake) begin
                    if (word_lo) begin
                        head    <= head + AW'(1);
                        word_lo <= 1'b0;
                    end else begin
                        word_lo <= 1'b1;
                    end
                end
                case ({push, pop})
                    2'b10:   level <= level + (AW + 1)'(1);
                    2'b01:   level <= level - (AW + 1)'(1);
                    default: level <= level;
                endcase
                if (push_req && full && !pop) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // Storage needs no reset; only entries between head and tail are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= inBlock64;
        end
    end

endmodule

// File: tb/tb_tea_output_collector.sv
// tb/tb_tea_output_collector.sv - scoreboard bench for tea_output_collector
module tb_tea_output_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b0;
    logic [63:0] inBlock64 = 64'h0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] outWord32;
    logic        out_last;
    logic        warm;
    logic [3:0]  level;
    logic        overflow;

    int errors = 0;
    int checks = 0;
    logic [32:0] exp_q[$];

    tea_output_collector #(.WARMUP(32), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .inBlock64 (inBlock64),
        .flush     (flush),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .outWord32 (outWord32),
        .out_last  (out_last),
        .warm      (warm),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_block(input logic [63:0] b);
        exp_q.push_back({1'b0, b[63:32]});
        exp_q.push_back({1'b1, b[31:0]});
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            tick();
            n++;
        end
        chk("drain_in_time", n < 200, 1);
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_level", level, 0);
    endtask

    // Every word accepted on the coming edge is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {out_last, outWord32}, 33'h1_dead_dead);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("word", outWord32, e[31:0]);
                chk("last", out_last, e[32]);
            end
        end
    end

    initial begin
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_word", outWord32, 0);
        chk("rst_last", out_last, 0);
        chk("rst_warm", warm, 0);
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow, 0);
        tick();
        rst = 1'b1;

        // Warm-up: blocks 0..31 dropped, 32 and 33 delivered
        out_ready = 1'b1;
        ena = 1'b1;
        for (int i = 0; i < 34; i++) begin
            inBlock64 = 64'(i);
            if (i >= 32) expect_block(64'(i));
            tick();
            if (i == 30) chk("warm_before", warm, 0);
            if (i == 31) chk("warm_after", warm, 1);
        end
        ena = 1'b0;
        drain();

        // Word order
        inBlock64 = 64'hDEAD_BEEF_0123_4567;
        expect_block(inBlock64);
        ena = 1'b1;
        tick();
        ena = 1'b0;
        chk("order_hi", outWord32, 32'hDEADBEEF);
        drain();
        chk("order_valid_end", out_valid, 0);

        // Backpressure and overflow
        out_ready = 1'b0;
        ena = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            inBlock64 = 64'(i);
            if (i <= 8) expect_block(64'(i));
            tick();
        end
        ena = 1'b0;
        chk("bp_level", level, 8);
        chk("bp_overflow", overflow, 1);
        chk("bp_valid", out_valid, 1);
        drain();
        chk("bp_overflow_sticky", overflow, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_clears_overflow", overflow, 0);

        // Full FIFO with simultaneous pop and push
        out_ready = 1'b0;
        ena = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            inBlock64 = 64'h100 + 64'(i);
            expect_block(inBlock64);
            tick();
        end
        ena = 1'b0;
        chk("full_level", level, 8);
        out_ready = 1'b1;
        tick();
        chk("full_low_phase", out_last, 1);
        ena = 1'b1;
        inBlock64 = 64'h1FF_0000_01FF;
        expect_block(inBlock64);
        tick();
        ena = 1'b0;
        chk("full_pushpop_level", level, 8);
        chk("full_pushpop_overflow", overflow, 0);
        drain();

        // Flush with a concurrent push
        out_ready = 1'b0;
        ena = 1'b1;
        for (int i = 0; i < 5; i++) begin
            inBlock64 = 64'h200 + 64'(i);
            tick();
        end
        chk("pre_flush_level", level, 5);
        flush = 1'b1;
        inBlock64 = 64'h2FF;
        tick();
        flush = 1'b0;
        ena = 1'b0;
        chk("flush_level", level, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_word", outWord32, 0);
        chk("flush_overflow", overflow, 0);
        chk("flush_warm", warm, 1);
        inBlock64 = 64'hAAAA_BBBB_CCCC_DDDD;
        expect_block(inBlock64);
        ena = 1'b1;
        tick();
        ena = 1'b0;
        chk("post_flush_first", outWord32, 32'hAAAABBBB);
        drain();

        // Async reset mid-block
        out_ready = 1'b1;
        inBlock64 = 64'h5555_6666_7777_8888;
        expect_block(inBlock64);
        ena = 1'b1;
        tick();
        ena = 1'b0;
        tick();
        chk("mid_low_phase", out_last, 1);
        #1;
        rst = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_valid", out_valid, 0);
        chk("arst_level", level, 0);
        chk("arst_warm", warm, 0);
        chk("arst_word", outWord32, 0);
        tick();
        rst = 1'b1;
        ena = 1'b1;
        for (int i = 0; i < 32; i++) begin
            inBlock64 = 64'hBAD0 + 64'(i);
            tick();
        end
        chk("rewarm_level", level, 0);
        chk("rewarm_warm", warm, 1);
        inBlock64 = 64'h1234_5678_9ABC_DEF0;
        expect_block(inBlock64);
        tick();
        ena = 1'b0;
        chk("rewarm_first", outWord32, 32'h12345678);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
